// File: rtl/data_mem_ctrl.sv
// Unified instruction/data store with a fixed-latency valid/ready request/response port.
// Optional misaligned-access trap: define DATA_MEM_CTRL_MISALIGN_TRAP_EN.
module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nx;
    logic        live;
    logic        accept;
    logic        fire;

    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_we;
    logic [2:0]  a_f3;

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic [31:0]   word;
    logic [7:0]    bsel;
    logic [15:0]   hsel;
    logic          illegal;
    logic          misal;
    logic          err;
    logic [31:0]   ld;
    logic [3:0]    mask;
    logic [31:0]   wd;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        fire     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid && live) begin
                    accept   = 1'b1;
                    cnt_nx   = 4'(LATENCY - 1);
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    fire     = 1'b1;
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign idx  = a_addr[AW+1:2];
    assign off  = a_addr[1:0];
    assign word = mem[idx];

    always_comb begin
        bsel = word[7:0];
        unique case (off)
            2'd0: bsel = word[7:0];
            2'd1: bsel = word[15:8];
            2'd2: bsel = word[23:16];
            2'd3: bsel = word[31:24];
            default: bsel = word[7:0];
        endcase
    end

    // Without the trap, half accesses round down to the aligned half.
    assign hsel = off[1] ? word[31:16] : word[15:0];

    always_comb begin
        illegal = 1'b0;
        unique case (a_f3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = a_we;
            default:                illegal = 1'b1;
        endcase
    end

`ifdef DATA_MEM_CTRL_MISALIGN_TRAP_EN
    assign misal = ((a_f3[1:0] == 2'b01) && off[0]) ||
                   ((a_f3[1:0] == 2'b10) && (off != 2'b00));
`else
    assign misal = 1'b0;
`endif

    assign err = illegal || misal;

    always_comb begin
        ld = 32'd0;
        unique case (1'b1)
            (a_f3 == 3'b000): ld = {{24{bsel[7]}}, bsel};
            (a_f3 == 3'b001): ld = {{16{hsel[15]}}, hsel};
            (a_f3 == 3'b010): ld = word;
            (a_f3 == 3'b100): ld = {24'd0, bsel};
            (a_f3 == 3'b101): ld = {16'd0, hsel};
            default:          ld = 32'd0;
        endcase
    end

    always_comb begin
        mask = 4'b0000;
        wd   = a_wdata;
        unique case (a_f3[1:0])
            2'b00: begin
                mask = 4'b0001 << off;
                wd   = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                mask = off[1] ? 4'b1100 : 4'b0011;
                wd   = {2{a_wdata[15:0]}};
            end
            2'b10: begin
                mask = 4'b1111;
                wd   = a_wdata;
            end
            default: begin
                mask = 4'b0000;
                wd   = a_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            live       <= 1'b0;
            a_addr     <= 32'd0;
            a_wdata    <= 32'd0;
            a_we       <= 1'b0;
            a_f3       <= 3'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            live  <= 1'b1;
            if (accept) begin
                a_addr  <= req_addr;
                a_wdata <= req_wdata;
                a_we    <= req_we;
                a_f3    <= req_func3;
            end
            if (fire) begin
                resp_rdata <= (err || a_we) ? 32'd0 : ld;
                resp_err   <= err;
            end else if (state == RESP && resp_ready) begin
                resp_rdata <= 32'd0;
                resp_err   <= 1'b0;
            end
        end
    end

    // Storage is deliberately not reset; a reset in WAIT suppresses the write.
    always_ff @(posedge clk) begin
        if (rst && fire && a_we && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) begin
                    mem[idx][8*i +: 8] <= wd[8*i +: 8];
                end
            end
        end
    end

    assign resp_valid = (state == RESP);
    assign req_ready  = (state == IDLE) && live;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: directed loads/stores, stall, reset abort.
// Expectations follow DATA_MEM_CTRL_MISALIGN_TRAP_EN when defined.
module tb_data_mem_ctrl;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic        req_we = 1'b0;
    logic [2:0]  req_func3 = 3'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;

    typedef struct packed {
        logic [31:0] rd;
        logic        er;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    bit          seen = 0;
    logic [31:0] hold_rd;
    logic        hold_er;

    data_mem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_func3 (req_func3),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            seen = 0;
        end else if (resp_valid) begin
            if (!seen) begin
                seen = 1;
                hold_rd = resp_rdata;
                hold_er = resp_err;
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_resp got rdata=%h", resp_rdata);
                end else if (cyc - q[0].acc != LAT) begin
                    fails++;
                    $display("FAIL latency got %0d want %0d", cyc - q[0].acc, LAT);
                end
            end else begin
                tests++;
                if (resp_rdata !== hold_rd || resp_err !== hold_er || req_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL hold got rd=%h er=%b rr=%b want rd=%h er=%b rr=0",
                             resp_rdata, resp_err, req_ready, hold_rd, hold_er);
                end
            end
            if (resp_ready) begin
                seen = 0;
                if (q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    tests++;
                    if (resp_rdata !== e.rd || resp_err !== e.er) begin
                        fails++;
                        $display("FAIL resp got rd=%h er=%b want rd=%h er=%b",
                                 resp_rdata, resp_err, e.rd, e.er);
                    end
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] er_d,
                         input logic er_e, input bit push = 1);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout got req_ready=0 want 1");
            return;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_func3 = f3;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1;
        if (push) q.push_back('{er_d, er_e, cyc});
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_we    = 1'($urandom);
        req_func3 = 3'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || resp_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout got %0d pending want 0", q.size());
            q.delete();
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("pre_edge_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("post_edge_ready", {31'd0, req_ready}, 32'd1);

        issue(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        issue(0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        issue(0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 0);
        issue(0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 0);
        issue(0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 0);
        issue(0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 0);
        issue(1, 3'b000, 32'h11, 32'h12345655, 32'h0, 0);
        issue(0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 0);

        issue(1, 3'b010, 32'h14, 32'h01020304, 32'h0, 0);
        issue(1, 3'b001, 32'h16, 32'hABCD7788, 32'h0, 0);
        issue(1, 3'b000, 32'h14, 32'hFFFFFF80, 32'h0, 0);
        issue(0, 3'b010, 32'h14, 32'h0, 32'h77880380, 0);
        issue(0, 3'b000, 32'h14, 32'h0, 32'hFFFFFF80, 0);
        issue(0, 3'b001, 32'h16, 32'h0, 32'h00007788, 0);
        issue(0, 3'b010, 32'h1010, 32'h0, 32'hDEAD55EF, 0);

        drain();
        resp_ready = 1'b0;
        issue(0, 3'b010, 32'h14, 32'h0, 32'h77880380, 0);
        repeat (LAT + 5) @(posedge clk);
        #1 resp_ready = 1'b1;
        drain();

`ifdef DATA_MEM_CTRL_MISALIGN_TRAP_EN
        issue(0, 3'b010, 32'h12, 32'h0, 32'h0, 1);
        issue(0, 3'b001, 32'h13, 32'h0, 32'h0, 1);
`else
        issue(0, 3'b010, 32'h12, 32'h0, 32'hDEAD55EF, 0);
        issue(0, 3'b001, 32'h13, 32'h0, 32'hFFFFDEAD, 0);
`endif
        issue(0, 3'b111, 32'h10, 32'h0, 32'h0, 1);
        issue(1, 3'b011, 32'h10, 32'h0, 32'h0, 1);
        issue(0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 0);

        issue(1, 3'b010, 32'h20, 32'h11223344, 32'h0, 0);
        drain();
        issue(1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 0, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_valid", {31'd0, resp_valid}, 32'd0);
        issue(0, 3'b010, 32'h20, 32'h0, 32'h11223344, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words in the unified instruction/data store (power of two).
REQ-002 The block SHALL have parameter LATENCY, default 2, cycles from request acceptance to response (legal range 1..15).
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 The block SHALL have port req_valid  input  1  core presents a memory request.
REQ-006 The block SHALL have port req_ready  output  1  controller accepts a request this cycle.
REQ-007 The block SHALL have port req_addr  input  32  byte address (core AdrSrc mux output).
REQ-008 The block SHALL have port req_we  input  1  1 = store, 0 = load/fetch (core MemWrite).
REQ-009 The block SHALL have port req_func3  input  3  access size/sign code (RISC-V funct3; fetch uses 010).
REQ-010 The block SHALL have port req_wdata  input  32  store data, least-significant lanes used for SB/SH.
REQ-011 The block SHALL have port resp_valid  output  1  response available.
REQ-012 The block SHALL have port resp_ready  input  1  core consumes the response.
REQ-013 The block SHALL have port resp_rdata  output  32  load result, already sign- or zero-extended.
REQ-014 The block SHALL have port resp_err  output  1  misaligned or illegal-size access (valid with resp_valid).

Function
REQ-015 The block SHALL implement FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 In IDLE, req_valid=1 SHALL latch addr/we/func3/wdata, load counter with LATENCY-1, and move to WAIT.
REQ-017 In WAIT, the counter SHALL decrement each cycle; at 0 the access SHALL be performed and the state SHALL move to RESP.
REQ-018 resp_valid SHALL rise exactly LATENCY cycles after the accept edge and SHALL hold with stable resp_rdata/resp_err until resp_ready=1.
REQ-019 In RESP with resp_ready=1, the state SHALL return to IDLE; a new request SHALL NOT be accepted in that same cycle (earliest accept is the following cycle).
REQ-020 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored (wrap-around).
REQ-021 Loads: 000 LB and 001 LH SHALL be sign-extended, 100 LBU and 101 LHU zero-extended, 010 LW full word; the byte/half SHALL be selected by addr[1:0].
REQ-022 Stores: 000 SB, 001 SH, 010 SW SHALL write only the addressed byte lanes; other lanes SHALL be unchanged.
REQ-023 For a store response, resp_rdata SHALL be 0.
REQ-024 funct3 codes 011, 110, 111 SHALL set resp_err=1; there SHALL be no write and resp_rdata SHALL be 0.
REQ-025 Inputs changing while in WAIT or RESP SHALL have no effect on the transaction in progress.

Reset
REQ-026 While rst=0 at an edge, the state SHALL be IDLE and the counter 0, and outputs SHALL be resp_valid=0, resp_rdata=0, resp_err=0, req_ready=0; req_ready SHALL be 1 from the first edge with rst=1.
REQ-027 Reset during WAIT SHALL abandon the transaction with no memory write; reset during RESP SHALL drop the response.
REQ-028 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-029 Macro DATA_MEM_CTRL_MISALIGN_TRAP_EN: when defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL give resp_err=1, no write, and resp_rdata=0.
REQ-030 Without DATA_MEM_CTRL_MISALIGN_TRAP_EN, misalignment SHALL never raise resp_err: a word access SHALL ignore addr[1:0], and a half access SHALL ignore addr[0].

Verification
REQ-031 SW 0xDEADBEEF @0x10, then LW @0x10 with LATENCY=2 -> resp_valid 2 cycles after each accept; rdata=0xDEADBEEF.
REQ-032 After that store, LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
REQ-033 SB 0x55 @0x11 -> LW @0x10 = 0xDEAD55EF.
REQ-034 resp_ready held 0 for 5 cycles -> resp_valid/rdata stable throughout; req_ready=0 until the cycle after the handshake.
REQ-035 SW @0x20 with rst=0 asserted during WAIT -> LW @0x20 after reset returns the prior contents, not the store data.
REQ-036 With the macro, LW @0x12 -> resp_err=1, rdata=0; without it -> rdata equals word @0x10, resp_err=0. funct3=111 -> resp_err=1 in both builds.
